// File: rtl/cntr8_pkg.sv
// Shared definitions for the cntr8 command sequencer: opcode constants,
// FSM state encodings, count width and the modulo-256 step helper.
package cntr8_pkg;

   localparam int CNT_W = 8;

   // Command opcodes carried on cmd_op
   localparam logic [2:0] OP_NOP   = 3'd0;
   localparam logic [2:0] OP_LOAD  = 3'd1;
   localparam logic [2:0] OP_INC   = 3'd2;
   localparam logic [2:0] OP_DEC   = 3'd3;
   localparam logic [2:0] OP_INC2  = 3'd4;
   localparam logic [2:0] OP_DEC2  = 3'd5;
   localparam logic [2:0] OP_RUNUP = 3'd6;
   localparam logic [2:0] OP_RUNDN = 3'd7;

   // Sequencer states; the remaining codes are illegal and recover to IDLE
   typedef enum logic [2:0] {
      ST_IDLE   = 3'b000,
      ST_RUN_UP = 3'b001,
      ST_RUN_DN = 3'b010
   } state_e;

   // Adds or subtracts amt (1 or 2) from val. Bit 8 of the result is the
   // carry/borrow out, i.e. the modulo-256 wrap indication; bits 7:0 are
   // the new count.
   function automatic logic [8:0] cnt8_step(input logic [7:0] val,
                                            input logic       up,
                                            input logic [1:0] amt);
      logic [8:0] res;
      if (up) begin
         res = {1'b0, val} + {7'b0000000, amt};
      end else begin
         res = {1'b0, val} - {7'b0000000, amt};
      end
      return res;
   endfunction

endpackage

// File: rtl/cntr8_ctrl_register3_s.sv
// 3-bit state register for the cntr8 sequencer.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset, clears the register to 000
//   d_i   - next-state value
//   q_o   - current state
module cntr8_ctrl_register3_s (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] d_i,
   output logic [2:0] q_o
);

   // State flop with synchronous reset to the IDLE code
   always_ff @(posedge clk) begin
      if (reset) begin
         q_o <= 3'b000;
      end else begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/cntr8_ctrl.sv
// Command-driven sequencer for an 8-bit counter. Accepts one command per
// valid/ready handshake and applies it to the count: load, +/-1, +/-2, or a
// multi-cycle run that steps the count once per clock for N cycles.
// Ports:
//   clk       - rising-edge clock
//   reset     - synchronous active-high reset
//   cmd_valid - command present
//   cmd_ready - controller idle and able to accept a command
//   cmd_op    - opcode (NOP, LOAD, INC, DEC, INC2, DEC2, RUNUP, RUNDN)
//   cmd_arg   - LOAD value or run length
//   cnt       - registered count
//   busy      - a run is in progress
//   done      - one-cycle completion pulse
//   wrap      - one-cycle pulse when the count wrapped modulo 256
module cntr8_ctrl
   import cntr8_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [2:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_arg,
   output logic [CNT_W-1:0] cnt,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   logic [2:0]       state_q;
   logic [2:0]       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] rem_q;
   logic [CNT_W-1:0] rem_d;
   logic             done_q;
   logic             done_d;
   logic             wrap_q;
   logic             wrap_d;
   logic             accept_s;
   logic [8:0]       step_s;

   cntr8_ctrl_register3_s u_state_reg (
      .clk   (clk),
      .reset (reset),
      .d_i   (state_d),
      .q_o   (state_q)
   );

   assign accept_s = cmd_valid && (state_q == ST_IDLE);

   // Next-state, count, remaining-steps and pulse computation
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      wrap_d  = 1'b0;
      step_s  = 9'd0;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               case (cmd_op)
                  OP_NOP: begin
                     done_d = 1'b1;
                  end
                  OP_LOAD: begin
                     cnt_d  = cmd_arg;
                     done_d = 1'b1;
                  end
                  OP_INC, OP_DEC, OP_INC2, OP_DEC2: begin
                     // opcode bit 0 clear means an up-step; ops 4/5 step by two
                     step_s = cnt8_step(cnt_q, ~cmd_op[0], cmd_op[2] ? 2'd2 : 2'd1);
                     cnt_d  = step_s[7:0];
                     wrap_d = step_s[8];
                     done_d = 1'b1;
                  end
                  OP_RUNUP, OP_RUNDN: begin
                     // A zero-length run behaves as a NOP
                     if (cmd_arg == 8'd0) begin
                        done_d = 1'b1;
                     end else begin
                        rem_d   = cmd_arg;
                        state_d = (cmd_op == OP_RUNUP) ? ST_RUN_UP : ST_RUN_DN;
                     end
                  end
                  default: begin
                     done_d = 1'b1;
                  end
               endcase
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN_UP, ST_RUN_DN: begin
            step_s = cnt8_step(cnt_q, (state_q == ST_RUN_UP), 2'd1);
            cnt_d  = step_s[7:0];
            wrap_d = step_s[8];
            rem_d  = rem_q - 8'd1;
            // Last step: leave the run and flag completion
            if (rem_q <= 8'd1) begin
               rem_d   = 8'd0;
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end else begin
               state_d = state_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            rem_d   = 8'd0;
         end
      endcase
   end

   // Count, remaining-steps and registered pulse flops
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= 8'd0;
         rem_q  <= 8'd0;
         done_q <= 1'b0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rem_q  <= rem_d;
         done_q <= done_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt       = cnt_q;
   assign done      = done_q;
   assign wrap      = wrap_q;
   assign busy      = (state_q != ST_IDLE);
   assign cmd_ready = (state_q == ST_IDLE);

endmodule
